// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shared FSM state and shift-op encodings
package shift_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;
endpackage

// File: rtl/shift_sequencer_shift_stage.sv
// shift_stage: one conditional power-of-two shift (2^k) of a 32-bit word
module shift_stage
  import shift_sequencer_pkg::*;
(
  input  logic [31:0] in,
  input  logic [2:0]  k,
  input  logic        enable,
  input  logic        op,
  output logic [31:0] out
);
  logic [4:0]         amt;
  logic signed [31:0] sra;
  logic [31:0]        sll;
  // sra is computed in its own signed variable so the ternary below cannot demote >>> to a logical shift
  always_comb begin
    amt = 5'd1 << k;
    sra = $signed(in) >>> amt;
    sll = in << amt;
    out = !enable ? in : (op == OP_SRA) ? sra : sll;
  end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle barrel shifter reusing one shift stage per cycle
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int EARLY_EXIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  state_t      state;
  logic [2:0]  k;
  logic [31:0] work;
  logic        op_q;
  logic [4:0]  shamt_q;
  logic [4:0]  rest;
  logic [31:0] stage_out;
  logic        last;
  logic        capture;

  assign result = work;

  // last stage when k hits 0, or earlier when no lower shamt bits remain and early exit is enabled
  always_comb begin
    rest    = shamt_q & ((5'd1 << k) - 5'd1);
    last    = (k == 3'd0) || (EARLY_EXIT != 0 && rest == 5'd0);
    capture = start && state != SHIFT;
  end

  shift_stage u_stage (
    .in     (work),
    .k      (k),
    .enable (shamt_q[k]),
    .op     (op_q),
    .out    (stage_out)
  );

  // FSM with registered busy/done; start is only honoured outside SHIFT
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      work    <= '0;
      k       <= 3'd4;
      op_q    <= OP_SLL;
      shamt_q <= '0;
    end else if (state == SHIFT) begin
      work  <= stage_out;
      k     <= k - 3'd1;
      state <= last ? DONE : SHIFT;
      busy  <= !last;
      done  <= last;
    end else if (capture) begin
      work    <= data_in;
      op_q    <= op;
      shamt_q <= shamt;
      k       <= 3'd4;
      state   <= SHIFT;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end
  end
endmodule
